ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers, delivering each stage its own control signals. It is the consuming end of the main decoder: it detects load-use hazards and drives the stall that the decoder and the front end consume. It also generates the EX-stage operand forwarding selects. It sits between the decoder/register-file read in ID and the ALU, data memory and write-back muxes.

## Interface
- Parameters: none (widths fixed by RV32I: register address 5 bits).
- clk_i  in  1  pipeline clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-low
- Branch_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegWrite_i  in  1 each  ID-stage control bundle from the decoder
- ALUOp_i  in  2  ID-stage ALU op class
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  register fields of the instruction in ID
- Flush_i  in  1  discard the instruction in ID (bubble into ID/EX)
- Stall_o  out  1  load-use stall: hold PC and IF/ID, decoder outputs bubble
- EX_ALUOp_o  out  2  ALU op class for EX
- EX_ALUSrc_o  out  1  immediate select for EX
- ForwardA_o, ForwardB_o  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- MEM_MemRead_o, MEM_MemWrite_o  out  1 each  data memory strobes
- WB_RegWrite_o, WB_MemtoReg_o  out  1 each  write-back enable and source
- WB_RDaddr_o  out  5  write-back destination
- StallCnt_o  out  32  count of stall cycles since reset

## Operation
- Three register stages. ID/EX holds the full bundle plus rs1, rs2 and rd. EX/MEM holds MemRead, MemWrite, RegWrite, MemtoReg and rd. MEM/WB holds RegWrite, MemtoReg and rd.
- Load-use hazard (Stall_o=1): EX.MemRead and EX.rd≠0 and (EX.rd==RS1addr_i or EX.rd==RS2addr_i).
- On a stall or Flush_i, ID/EX loads a bubble: all controls 0 and addresses 0. EX/MEM and MEM/WB advance normally.
- This block inserts the bubble itself. It does not rely on the decoder having zeroed the bundle.
- Flush_i and stall in the same cycle produce a single bubble. Stall_o is still asserted.
- ForwardA: 10 if MEM.RegWrite, MEM.rd≠0 and MEM.rd==EX.rs1. Otherwise 01 if WB.RegWrite, WB.rd≠0 and WB.rd==EX.rs1. Otherwise 00. ForwardB is the same using EX.rs2.
- EX/MEM takes priority over MEM/WB when both match.
- rd==x0 never forwards and never stalls.
- Write-back to a register read in the same cycle is handled by the register file (write-first). It is not handled here.
- StallCnt_o increments once per cycle with Stall_o=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (rst_i=0 at a clock edge): every stage register becomes a bubble and StallCnt_o becomes 0.
- Consequently, in the first cycle after reset: Stall_o=0, Forward*=00, and every stage output is 0.
- Reset has priority over stall and flush. A reset mid-stall clears the hazard on the next edge.
- ID bundle to EX outputs: 1 cycle. To MEM outputs: 2 cycles. To WB outputs: 3 cycles.
- Stall_o and Forward* are combinational from the stage registers and the ID inputs, valid in the same cycle.
- A load followed by a dependent instruction produces exactly one stall cycle. The dependent instruction then sees ForwardX=01 in EX.

## Configuration
- CTRL_PIPE_FWD_EN defined: forwarding as above, and only load-use stalls.
- CTRL_PIPE_FWD_EN undefined: ForwardA_o and ForwardB_o are tied to 00.
- Without forwarding, Stall_o asserts for any RAW hazard: (EX.RegWrite, EX.rd≠0, EX.rd matches rs1 or rs2) or (MEM.RegWrite, MEM.rd≠0, MEM.rd matches rs1 or rs2).
- A back-to-back dependent ALU pair therefore stalls 2 cycles.

## Structure
- Package ctrl_pipe_pkg contains:
  - typedef of the control-bundle struct
  - forward-select constants FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01
  - bubble constant
- Sub-module ctrl_fwd_unit is combinational. It computes Stall_o and the Forward selects from the stage-register fields, and is the only place CTRL_PIPE_FWD_EN is tested.

## Test plan
- Reset: hold rst_i=0 for 2 cycles with a random ID bundle -> all outputs 0, StallCnt_o=0.
- Plain flow: lw x5 bundle (MemRead=1, RegWrite=1, MemtoReg=1, rd=5), followed by nops -> MEM_MemRead_o=1 at cycle +2; WB_RegWrite_o=1, WB_MemtoReg_o=1, WB_RDaddr_o=5 at cycle +3.
- Load-use: lw x5, then add with rs1=5 -> Stall_o=1 for one cycle, bubble in EX, then ForwardA_o=01; StallCnt_o=1.
- Forward priority: add x7 then add x7 then add using rs2=7 -> ForwardB_o=10 (newest producer), not 01.
- x0 and flush: lw x0 then use rs1=0 -> Stall_o=0, ForwardA_o=00; Flush_i=1 with RegWrite_i=1 -> EX outputs 0 next cycle, WB_RegWrite_o=0 two cycles later.
- Macro off: add x3 then sub with rs1=3 -> Stall_o=1 for 2 cycles, Forward*=00.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: control-bundle types, forward-select encodings and bubble constants
// shared by the control pipeline and its hazard/forwarding unit.
package ctrl_pipe_pkg;

   typedef struct packed {
      logic       branch;
      logic       mem_to_reg;
      logic       mem_write;
      logic       mem_read;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   typedef struct packed {
      ctrl_t      ctrl;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } id_ex_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] rd;
   } ex_mem_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic [4:0] rd;
   } mem_wb_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam ctrl_t   CTRL_BUBBLE   = '0;
   localparam id_ex_t  ID_EX_BUBBLE  = '{ctrl: CTRL_BUBBLE, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
   localparam ex_mem_t EX_MEM_BUBBLE = '0;
   localparam mem_wb_t MEM_WB_BUBBLE = '0;

   // A stage produces a value for rs only if it writes a non-x0 register named rs.
   function automatic logic writes_reg(input logic wr, input logic [4:0] rd, input logic [4:0] rs);
      return wr && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/ctrl_fwd_unit.sv
// ctrl_fwd_unit: combinational stall and EX operand-forward selection.
// CTRL_PIPE_FWD_EN selects forwarding with load-use stalls; otherwise every RAW hazard stalls.
module ctrl_fwd_unit
   import ctrl_pipe_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic [4:0] ex_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_rd,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_rd,
   output logic       stall,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

`ifdef CTRL_PIPE_FWD_EN
   // Only a load in EX cannot be forwarded in time; its data appears after MEM.
   assign stall = writes_reg(ex_mem_read, ex_rd, id_rs1) || writes_reg(ex_mem_read, ex_rd, id_rs2);

   // EX/MEM is the newer producer, so it is tested first.
   assign fwd_a = writes_reg(mem_reg_write, mem_rd, ex_rs1) ? FWD_MEM :
                  writes_reg(wb_reg_write,  wb_rd,  ex_rs1) ? FWD_WB  : FWD_RF;
   assign fwd_b = writes_reg(mem_reg_write, mem_rd, ex_rs2) ? FWD_MEM :
                  writes_reg(wb_reg_write,  wb_rd,  ex_rs2) ? FWD_WB  : FWD_RF;

   logic unused_fwd_en;
   assign unused_fwd_en = ex_reg_write;
`else
   // The register file resolves WB-stage writes, so only EX and MEM producers block.
   assign stall = writes_reg(ex_reg_write,  ex_rd,  id_rs1) || writes_reg(ex_reg_write,  ex_rd,  id_rs2) ||
                  writes_reg(mem_reg_write, mem_rd, id_rs1) || writes_reg(mem_reg_write, mem_rd, id_rs2);
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;

   logic unused_fwd_dis;
   assign unused_fwd_dis = ^{ex_mem_read, ex_rs1, ex_rs2, wb_reg_write, wb_rd};
`endif

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB,
// inserting bubbles on stall/flush. Define CTRL_PIPE_FWD_EN to enable EX forwarding.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        Branch_i,
   input  logic        MemtoReg_i,
   input  logic        MemWrite_i,
   input  logic        MemRead_i,
   input  logic        ALUSrc_i,
   input  logic        RegWrite_i,
   input  logic [1:0]  ALUOp_i,
   input  logic [4:0]  RS1addr_i,
   input  logic [4:0]  RS2addr_i,
   input  logic [4:0]  RDaddr_i,
   input  logic        Flush_i,
   output logic        Stall_o,
   output logic [1:0]  EX_ALUOp_o,
   output logic        EX_ALUSrc_o,
   output logic [1:0]  ForwardA_o,
   output logic [1:0]  ForwardB_o,
   output logic        MEM_MemRead_o,
   output logic        MEM_MemWrite_o,
   output logic        WB_RegWrite_o,
   output logic        WB_MemtoReg_o,
   output logic [4:0]  WB_RDaddr_o,
   output logic [31:0] StallCnt_o
);

   id_ex_t      id_ex_q;
   id_ex_t      id_ex_d;
   ex_mem_t     ex_mem_q;
   mem_wb_t     mem_wb_q;
   logic [31:0] stall_cnt_q;
   logic        stall;

   ctrl_fwd_unit u_fwd (
      .id_rs1        (RS1addr_i),
      .id_rs2        (RS2addr_i),
      .ex_mem_read   (id_ex_q.ctrl.mem_read),
      .ex_reg_write  (id_ex_q.ctrl.reg_write),
      .ex_rs1        (id_ex_q.rs1),
      .ex_rs2        (id_ex_q.rs2),
      .ex_rd         (id_ex_q.rd),
      .mem_reg_write (ex_mem_q.reg_write),
      .mem_rd        (ex_mem_q.rd),
      .wb_reg_write  (mem_wb_q.reg_write),
      .wb_rd         (mem_wb_q.rd),
      .stall         (stall),
      .fwd_a         (ForwardA_o),
      .fwd_b         (ForwardB_o)
   );

   // NOTE: defaulting id_ex_d to the bubble first keeps this block latch-free and
   // makes the bubble independent of whatever the decoder drives during a stall.
   always_comb begin
      id_ex_d = ID_EX_BUBBLE;
      if (!(stall || Flush_i)) begin
         id_ex_d.ctrl.branch     = Branch_i;
         id_ex_d.ctrl.mem_to_reg = MemtoReg_i;
         id_ex_d.ctrl.mem_write  = MemWrite_i;
         id_ex_d.ctrl.mem_read   = MemRead_i;
         id_ex_d.ctrl.alu_src    = ALUSrc_i;
         id_ex_d.ctrl.reg_write  = RegWrite_i;
         id_ex_d.ctrl.alu_op     = ALUOp_i;
         id_ex_d.rs1             = RS1addr_i;
         id_ex_d.rs2             = RS2addr_i;
         id_ex_d.rd              = RDaddr_i;
      end
   end

   // NOTE: non-blocking assignments so each stage captures its predecessor's pre-edge value.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         id_ex_q     <= ID_EX_BUBBLE;
         ex_mem_q    <= EX_MEM_BUBBLE;
         mem_wb_q    <= MEM_WB_BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= '{mem_read:   id_ex_q.ctrl.mem_read,
                       mem_write:  id_ex_q.ctrl.mem_write,
                       reg_write:  id_ex_q.ctrl.reg_write,
                       mem_to_reg: id_ex_q.ctrl.mem_to_reg,
                       rd:         id_ex_q.rd};
         mem_wb_q <= '{reg_write:  ex_mem_q.reg_write,
                       mem_to_reg: ex_mem_q.mem_to_reg,
                       rd:         ex_mem_q.rd};
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   // Branch rides along in ID/EX for an EX-stage resolver; nothing here consumes it.
   logic unused_ex_branch;
   assign unused_ex_branch = id_ex_q.ctrl.branch;

   assign Stall_o        = stall;
   assign EX_ALUOp_o     = id_ex_q.ctrl.alu_op;
   assign EX_ALUSrc_o    = id_ex_q.ctrl.alu_src;
   assign MEM_MemRead_o  = ex_mem_q.mem_read;
   assign MEM_MemWrite_o = ex_mem_q.mem_write;
   assign WB_RegWrite_o  = mem_wb_q.reg_write;
   assign WB_MemtoReg_o  = mem_wb_q.mem_to_reg;
   assign WB_RDaddr_o    = mem_wb_q.rd;
   assign StallCnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe with an instruction-level pipeline model
// checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_ctrl_pipe;

   typedef struct packed {
      bit       br;
      bit       m2r;
      bit       mw;
      bit       mr;
      bit       asrc;
      bit       rw;
      bit [1:0] op;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit [4:0] rd;
   } inst_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        Branch_i, MemtoReg_i, MemWrite_i, MemRead_i, ALUSrc_i, RegWrite_i;
   logic [1:0]  ALUOp_i;
   logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
   logic        Flush_i;
   logic        Stall_o;
   logic [1:0]  EX_ALUOp_o;
   logic        EX_ALUSrc_o;
   logic [1:0]  ForwardA_o, ForwardB_o;
   logic        MEM_MemRead_o, MEM_MemWrite_o;
   logic        WB_RegWrite_o, WB_MemtoReg_o;
   logic [4:0]  WB_RDaddr_o;
   logic [31:0] StallCnt_o;

   inst_t id;
   bit    flush;
   int    n_cmp  = 0;
   int    n_fail = 0;

   assign Branch_i   = id.br;
   assign MemtoReg_i = id.m2r;
   assign MemWrite_i = id.mw;
   assign MemRead_i  = id.mr;
   assign ALUSrc_i   = id.asrc;
   assign RegWrite_i = id.rw;
   assign ALUOp_i    = id.op;
   assign RS1addr_i  = id.rs1;
   assign RS2addr_i  = id.rs2;
   assign RDaddr_i   = id.rd;
   assign Flush_i    = flush;

   ctrl_pipe dut (
      .clk_i(clk), .rst_i(rst_i),
      .Branch_i(Branch_i), .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i),
      .MemRead_i(MemRead_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
      .ALUOp_i(ALUOp_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
      .RDaddr_i(RDaddr_i), .Flush_i(Flush_i), .Stall_o(Stall_o),
      .EX_ALUOp_o(EX_ALUOp_o), .EX_ALUSrc_o(EX_ALUSrc_o),
      .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
      .MEM_MemRead_o(MEM_MemRead_o), .MEM_MemWrite_o(MEM_MemWrite_o),
      .WB_RegWrite_o(WB_RegWrite_o), .WB_MemtoReg_o(WB_MemtoReg_o),
      .WB_RDaddr_o(WB_RDaddr_o), .StallCnt_o(StallCnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- instruction-level model ----------------
   inst_t     m_ex, m_mem, m_wb;
   bit [31:0] m_cnt;
   bit        model_ok = 0;

   function automatic bit produces(inst_t p, bit [4:0] rs);
      return p.rw && p.rd != 0 && p.rd == rs;
   endfunction

   function automatic bit exp_stall();
`ifdef CTRL_PIPE_FWD_EN
      return m_ex.mr && m_ex.rd != 0 && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
`else
      return produces(m_ex, id.rs1) || produces(m_ex, id.rs2) ||
             produces(m_mem, id.rs1) || produces(m_mem, id.rs2);
`endif
   endfunction

   function automatic bit [1:0] exp_fwd(bit [4:0] rs);
`ifdef CTRL_PIPE_FWD_EN
      if (produces(m_mem, rs)) return 2'b10;
      if (produces(m_wb, rs))  return 2'b01;
`endif
      return 2'b00;
   endfunction

   always @(posedge clk) begin
      if (!rst_i) begin
         m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
      end else begin
         bit s;
         s = exp_stall();
         if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = (s || flush) ? inst_t'(0) : id;
      end
      model_ok = 1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("m_stall",    Stall_o,        exp_stall());
         check("m_fwd_a",    ForwardA_o,     exp_fwd(m_ex.rs1));
         check("m_fwd_b",    ForwardB_o,     exp_fwd(m_ex.rs2));
         check("m_ex_aluop", EX_ALUOp_o,     m_ex.op);
         check("m_ex_alusrc",EX_ALUSrc_o,    m_ex.asrc);
         check("m_mem_rd",   MEM_MemRead_o,  m_mem.mr);
         check("m_mem_wr",   MEM_MemWrite_o, m_mem.mw);
         check("m_wb_rw",    WB_RegWrite_o,  m_wb.rw);
         check("m_wb_m2r",   WB_MemtoReg_o,  m_wb.m2r);
         check("m_wb_rd",    WB_RDaddr_o,    m_wb.rd);
         check("m_cnt",      StallCnt_o,     m_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic inst_t mk(bit mr, bit mw, bit rw, bit m2r, bit asrc, bit [1:0] op,
                                bit [4:0] rs1, bit [4:0] rs2, bit [4:0] rd);
      inst_t i = '0;
      i.mr = mr; i.mw = mw; i.rw = rw; i.m2r = m2r; i.asrc = asrc; i.op = op;
      i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
      return i;
   endfunction

   task automatic drive(input inst_t i, input bit f);
      id = i; flush = f;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic drain();
      repeat (3) begin drive('0, 0); adv(); end
   endtask

   // Hold an instruction in ID until it is accepted; counts observed stall cycles.
   task automatic issue(input inst_t i, output int n);
      bit s;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         drive(i, 0);
         s = exp_stall();
         if (Stall_o === 1'b1) n++;
         adv();
         if (!s) return;
      end
      n_cmp++; n_fail++;
      $display("FAIL issue_budget at %0t: instruction not accepted within 6 cycles", $time);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      inst_t nop, lw5, sw, add5, a7a, a7b, use7, lw0, use0, fl, add3, sub3;
      logic [22:0] rv;
      int n;

      nop  = '0;
      lw5  = mk(1, 0, 1, 1, 1, 2'b00, 5'd1, 5'd0, 5'd5);
      sw   = mk(0, 1, 0, 0, 1, 2'b00, 5'd2, 5'd6, 5'd0);
      add5 = mk(0, 0, 1, 0, 0, 2'b10, 5'd5, 5'd6, 5'd8);
      a7a  = mk(0, 0, 1, 0, 0, 2'b10, 5'd2, 5'd3, 5'd7);
      a7b  = mk(0, 0, 1, 0, 0, 2'b10, 5'd1, 5'd4, 5'd7);
      use7 = mk(0, 0, 1, 0, 0, 2'b10, 5'd4, 5'd7, 5'd9);
      lw0  = mk(1, 0, 1, 1, 1, 2'b00, 5'd1, 5'd0, 5'd0);
      use0 = mk(0, 0, 1, 0, 0, 2'b10, 5'd0, 5'd0, 5'd3);
      fl   = mk(0, 0, 1, 0, 1, 2'b11, 5'd0, 5'd0, 5'd10);
      add3 = mk(0, 0, 1, 0, 0, 2'b10, 5'd1, 5'd2, 5'd3);
      sub3 = mk(0, 0, 1, 0, 0, 2'b10, 5'd3, 5'd4, 5'd11);

      // Reset with a random bundle presented in ID
      rst_i = 1'b0;
      rv = 23'($urandom);
      id = rv; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_stall",  Stall_o,       0);
      check("rst_fwd_a",  ForwardA_o,    0);
      check("rst_ex_op",  EX_ALUOp_o,    0);
      check("rst_mem_rd", MEM_MemRead_o, 0);
      check("rst_wb_rw",  WB_RegWrite_o, 0);
      check("rst_wb_rd",  WB_RDaddr_o,   0);
      check("rst_cnt",    StallCnt_o,    0);
      adv();
      rst_i = 1'b1;
      drain();

      // Plain flow: lw x5, nop, sw, nop, nop
      drive(lw5, 0); adv();
      drive(nop, 0); check("lw_ex_alusrc", EX_ALUSrc_o, 1); adv();
      drive(sw, 0);  check("lw_mem_read", MEM_MemRead_o, 1); adv();
      drive(nop, 0);
      check("lw_wb_rw",  WB_RegWrite_o, 1);
      check("lw_wb_m2r", WB_MemtoReg_o, 1);
      check("lw_wb_rd",  WB_RDaddr_o,   5);
      adv();
      drive(nop, 0); check("sw_mem_write", MEM_MemWrite_o, 1); adv();
      drain();

      // Load-use
      drive(lw5, 0); adv();
      drive(add5, 0); check("lu_stall", Stall_o, 1); adv();
`ifdef CTRL_PIPE_FWD_EN
      drive(add5, 0);
      check("lu_stall_done", Stall_o, 0);
      check("lu_bubble_op",  EX_ALUOp_o, 0);
      check("lu_cnt",        StallCnt_o, 1);
      adv();
      drive(nop, 0);
      check("lu_fwd_a", ForwardA_o, 2'b01);
      check("lu_ex_op", EX_ALUOp_o, 2'b10);
      adv();
`else
      drive(add5, 0);
      check("lu_stall2",    Stall_o, 1);
      check("lu_bubble_op", EX_ALUOp_o, 0);
      check("lu_cnt1",      StallCnt_o, 1);
      adv();
      drive(add5, 0);
      check("lu_stall_done", Stall_o, 0);
      check("lu_cnt2",       StallCnt_o, 2);
      adv();
      drive(nop, 0);
      check("lu_fwd_a", ForwardA_o, 2'b00);
      check("lu_ex_op", EX_ALUOp_o, 2'b10);
      adv();
`endif
      drain();

      // Forward priority: two producers of x7, consumer on rs2
      drive(a7a, 0); adv();
      drive(a7b, 0); adv();
      issue(use7, n);
      drive(nop, 0);
`ifdef CTRL_PIPE_FWD_EN
      check("prio_stalls", n, 0);
      check("prio_fwd_b",  ForwardB_o, 2'b10);
`else
      check("prio_stalls", n, 2);
      check("prio_fwd_b",  ForwardB_o, 2'b00);
`endif
      check("prio_fwd_a", ForwardA_o, 2'b00);
      adv();
      drain();

      // x0 never stalls or forwards
      drive(lw0, 0); adv();
      drive(use0, 0); check("x0_stall", Stall_o, 0); adv();
      drive(nop, 0);  check("x0_fwd_a", ForwardA_o, 0); adv();

      // Flush turns a writing instruction into a bubble
      drive(fl, 1); adv();
      drive(nop, 0);
      check("fl_ex_op",  EX_ALUOp_o,  0);
      check("fl_ex_src", EX_ALUSrc_o, 0);
      adv();
      drive(nop, 0); adv();
      drive(nop, 0);
      check("fl_wb_rw", WB_RegWrite_o, 0);
      check("fl_wb_rd", WB_RDaddr_o,   0);
      adv();
      drain();

      // Flush and stall together give one bubble, stall still visible
      drive(lw5, 0); adv();
      drive(add5, 1); check("fs_stall", Stall_o, 1); adv();
      issue(add5, n);
      drain();

      // Reset in the middle of a stall
      drive(lw5, 0); adv();
      rst_i = 1'b0;
      drive(add5, 0); check("rs_stall_before", Stall_o, 1); adv();
      rst_i = 1'b1;
      drive(add5, 0);
      check("rs_stall_after", Stall_o, 0);
      check("rs_cnt",         StallCnt_o, 0);
      check("rs_mem_rd",      MEM_MemRead_o, 0);
      adv();
      drain();

      // Back-to-back dependent ALU pair
      drive(add3, 0); adv();
      issue(sub3, n);
      drive(nop, 0);
`ifdef CTRL_PIPE_FWD_EN
      check("alu_pair_stalls", n, 0);
      check("alu_pair_fwd_a",  ForwardA_o, 2'b10);
`else
      check("alu_pair_stalls", n, 2);
      check("alu_pair_fwd_a",  ForwardA_o, 2'b00);
`endif
      adv();
      drain();

      // Short random phase on a small register set, checked by the model
      for (int k = 0; k < 80; k++) begin
         inst_t r;
         rv = 23'($urandom);
         r = rv;
         r.rs1 = 5'($urandom_range(3, 0));
         r.rs2 = 5'($urandom_range(3, 0));
         r.rd  = 5'($urandom_range(3, 0));
         drive(r, ($urandom_range(7, 0) == 0));
         adv();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
